display_scan_driver: RTL and testbench
======================================

// Module: display_scan_driver
// PURPOSE
//   Time-multiplexed scan driver for an NDIG-digit seven-segment display.
//   Holds a packed NDIG x 4-bit display value and presents one nibble per scan
//   slot on digit_out, which feeds the 4-bit input of the seven-segment decoder.
//   Drives a one-hot digit enable with a blanking guard between slots to
//   prevent ghosting. Accepts new values via valid/ready; swaps them in only at
//   frame boundaries, so a frame never shows a torn value.
// PARAMETERS
//   NDIG            4     number of digits; >=2
//   TICKS_PER_DIGIT 1000  clk cycles per scan slot (blank + show); >=2
//   BLANK_TICKS     50    guard cycles at slot start, digit_sel all-zero; 1..TICKS_PER_DIGIT-1
// PORTS
//   clk        in   1        system clock, rising edge
//   rst        in   1        asynchronous reset, active-high
//   load       in   1        valid: digits_in/dp_in present a new value
//   load_ready out  1        ready: shadow register empty
//   digits_in  in   NDIG*4   packed nibbles; [3:0] = digit 0 (least significant)
//   dp_in      in   NDIG     decimal-point request per digit
//   digit_out  out  4        current nibble to the seven-segment decoder
//   dp_out     out  1        decimal point for the current digit
//   digit_sel  out  NDIG     one-hot digit enable, active-high; all-zero while blanking
//   blank      out  1        1 during the guard interval
//   frame_done out  1        1-cycle pulse on the last cycle of digit NDIG-1's slot
// BEHAVIOUR
//   Reset (async, immediate): state=BLANK, idx=0, prescaler=0, active=0, shadow empty;
//     digit_out=0, dp_out=0, digit_sel=0, blank=1, frame_done=0, load_ready=1.
//   All outputs are registered. Prescaler width is $clog2(TICKS_PER_DIGIT).
//     It counts 0..TICKS_PER_DIGIT-1 and wraps.
//   FSM: BLANK (prescaler < BLANK_TICKS) -> SHOW (remaining cycles) -> BLANK of next slot.
//     BLANK: digit_sel=0, blank=1, digit_out/dp_out already show digit idx (setup).
//     SHOW:  digit_sel[idx]=1, blank=0; digit_out/dp_out hold steady for the slot.
//   idx advances on the last cycle of each slot, wrapping NDIG-1 -> 0.
//     frame_done is asserted on that cycle when idx==NDIG-1.
//   Handshake: a transfer occurs when load && load_ready.
//     Data is captured into the shadow register; load_ready falls the next cycle.
//     load while !load_ready is ignored; the source must hold the value.
//   Frame boundary (frame_done cycle): if the shadow is full, shadow -> active,
//     load_ready=1 the next cycle, and the new value is displayed from digit 0.
//     Load and boundary in the same cycle with the shadow empty: the value goes to
//     the shadow and is displayed at the next boundary.
//   The initial active value after reset is all-zero; it scans immediately.
//   Mid-operation reset: the scan restarts at digit 0 in BLANK and the shadow is discarded.
// CONFIGURATION
//   DISPLAY_LZB_EN defined: leading-zero blanking. Starting from digit NDIG-1
//     and moving down, a digit whose active nibble is 0 and whose dp bit is 0 is
//     suppressed: digit_sel stays 0 through its SHOW, and blank=1 for the whole slot.
//     Suppression stops at the first nonzero or dp digit. Digit 0 is never suppressed.
//     The suppression mask is computed from the active register.
//   DISPLAY_LZB_EN undefined: every digit is shown; no mask logic.
// STRUCTURE
//   Package display_scan_pkg: state enum {BLANK, SHOW}, nibble width localparam
//     (4), and the function computing the leading-zero mask.
//   Sub-module scan_prescaler: a counter with a terminal-count output and a
//     guard-compare output.
//   The top module holds the FSM, idx, the shadow/active registers and the
//     handshake.
// TESTING (NDIG=4, TICKS_PER_DIGIT=8, BLANK_TICKS=2)
//   Assert rst -> digit_sel=0, digit_out=0, blank=1, load_ready=1, frame_done=0.
//   Load 16'h1234, dp=0 -> from the next frame, digit_out=4,3,2,1.
//     digit_sel=0001/0010/0100/1000, each high 6 cycles after a 2-cycle blank.
//   Load 16'h1111 then 16'h2222 in the same frame -> the second load is not
//     accepted (load_ready=0). The next frame shows 1111. 2222 is accepted after
//     the boundary and shows one frame later.
//   Free run -> frame_done pulses exactly once every 32 cycles, on the last
//     cycle of digit 3's slot.
//   Assert rst during digit 2 SHOW -> digit_sel=0 immediately with no clock edge.
//     After release, the scan restarts at digit 0 in BLANK.
//   Load 16'h0045, dp=0 -> with DISPLAY_LZB_EN, digit_sel bits 3 and 2 are never
//     set. Without it, digits 3 and 2 show 0. With dp=4'b0100, digit 2 shows 0
//     and only digit 3 is suppressed.

Source files
------------

// File: rtl/display_scan_driver_pkg.sv
// Shared types and helpers for the seven-segment scan driver.
// lzb_mask is only referenced when DISPLAY_LZB_EN is defined.
package display_scan_pkg;

   typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} scan_state_t;

   localparam int NIB_W   = 4;
   localparam int MAX_DIG = 16;

   // Digits are suppressed from the top down until the first nonzero nibble or dp bit.
   // Digit 0 is never suppressed.
   function automatic logic [MAX_DIG-1:0] lzb_mask(
      input logic [MAX_DIG*NIB_W-1:0] digits,
      input logic [MAX_DIG-1:0]       dp,
      input int                       ndig
   );
      logic [MAX_DIG-1:0] mask;
      logic               run;
      mask = '0;
      run  = 1'b1;
      for (int i = MAX_DIG-1; i >= 1; i--) begin
         if (i < ndig) begin
            if (digits[i*NIB_W +: NIB_W] != '0 || dp[i]) run = 1'b0;
            mask[i] = run;
         end
      end
      return mask;
   endfunction

endpackage

// File: rtl/display_scan_driver_if.sv
// Load handshake and display-side signals of the scan driver.
// The master modport is the value source; the slave modport is the driver.
interface display_scan_driver_if #(parameter int NDIG = 4);
   logic              load;
   logic              load_ready;
   logic [NDIG*4-1:0] digits_in;
   logic [NDIG-1:0]   dp_in;
   logic [3:0]        digit_out;
   logic              dp_out;
   logic [NDIG-1:0]   digit_sel;
   logic              blank;
   logic              frame_done;

   modport master (
      output load, digits_in, dp_in,
      input  load_ready, digit_out, dp_out, digit_sel, blank, frame_done
   );

   modport slave (
      input  load, digits_in, dp_in,
      output load_ready, digit_out, dp_out, digit_sel, blank, frame_done
   );
endinterface

// File: rtl/display_scan_driver_prescaler.sv
// Slot prescaler: counts 0..TICKS-1 and wraps, with compares for the
// last cycle of the slot, the cycle before it, and the last guard cycle.
module scan_prescaler #(
   parameter int TICKS = 1000,
   parameter int GUARD = 50
) (
   input  logic clk,
   input  logic rst,
   output logic o_tc,
   output logic o_tc_early,
   output logic o_guard_end
);
   localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;

   logic [CW-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       r_count <= '0;
      else if (o_tc) r_count <= '0;
      else           r_count <= r_count + 1'b1;
   end

   assign o_tc        = (r_count == CW'(TICKS - 1));
   assign o_tc_early  = (r_count == CW'(TICKS - 2));
   assign o_guard_end = (r_count == CW'(GUARD - 1));
endmodule

// File: rtl/display_scan_driver.sv
// Time-multiplexed seven-segment scan driver with frame-synchronous value swap.
// Define DISPLAY_LZB_EN to enable leading-zero blanking.
//
// state | meaning
// BLANK | guard interval, digit_sel all-zero, digit_out already set up
// SHOW  | digit idx enabled (unless suppressed) for the rest of the slot
module display_scan_driver
   import display_scan_pkg::*;
#(
   parameter int NDIG            = 4,
   parameter int TICKS_PER_DIGIT = 1000,
   parameter int BLANK_TICKS     = 50
) (
   input  logic                clk,
   input  logic                rst,
   display_scan_driver_if.slave bus
);
   localparam int IW = $clog2(NDIG);

   scan_state_t             r_state;
   logic [IW-1:0]           r_idx;
   logic [NDIG*NIB_W-1:0]   r_active, r_shadow;
   logic [NDIG-1:0]         r_active_dp, r_shadow_dp;
   logic                    r_load_ready;
   logic [NIB_W-1:0]        r_digit_out;
   logic                    r_dp_out;
   logic [NDIG-1:0]         r_digit_sel;
   logic                    r_blank;
   logic                    r_frame_done;

   logic                    w_tc, w_tc_early, w_guard_end;
   logic                    w_last, w_swap, w_take;
   logic [IW-1:0]           w_idx_next;
   logic [NDIG*NIB_W-1:0]   w_next_active;
   logic [NDIG-1:0]         w_next_dp;
   logic [NIB_W-1:0]        w_next_nib;
   logic                    w_next_dp_bit;
   logic [NDIG-1:0]         w_onehot;
   logic [NDIG-1:0]         w_suppress;

   scan_prescaler #(.TICKS(TICKS_PER_DIGIT), .GUARD(BLANK_TICKS)) u_prescaler (
      .clk         (clk),
      .rst         (rst),
      .o_tc        (w_tc),
      .o_tc_early  (w_tc_early),
      .o_guard_end (w_guard_end)
   );

   assign w_last     = (r_idx == IW'(NDIG - 1));
   assign w_swap     = w_tc && w_last && !r_load_ready;
   assign w_take     = bus.load && r_load_ready;
   assign w_idx_next = w_last ? '0 : r_idx + 1'b1;
   assign w_onehot   = NDIG'(1) << r_idx;

   // The first digit of a new frame must come from the value being swapped in.
   always_comb begin
      w_next_active = w_swap ? r_shadow    : r_active;
      w_next_dp     = w_swap ? r_shadow_dp : r_active_dp;
      w_next_nib    = w_next_active[w_idx_next*NIB_W +: NIB_W];
      w_next_dp_bit = w_next_dp[w_idx_next];
   end

`ifdef DISPLAY_LZB_EN
   logic [MAX_DIG*NIB_W-1:0] w_pad_digits;
   logic [MAX_DIG-1:0]       w_pad_dp;
   logic [MAX_DIG-1:0]       w_mask_full;

   always_comb begin
      w_pad_digits                  = '0;
      w_pad_digits[NDIG*NIB_W-1:0]  = r_active;
      w_pad_dp                      = '0;
      w_pad_dp[NDIG-1:0]            = r_active_dp;
   end

   assign w_mask_full = lzb_mask(w_pad_digits, w_pad_dp, NDIG);
   assign w_suppress  = w_mask_full[NDIG-1:0];
`else
   assign w_suppress = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= BLANK;
         r_idx        <= '0;
         r_active     <= '0;
         r_active_dp  <= '0;
         r_shadow     <= '0;
         r_shadow_dp  <= '0;
         r_load_ready <= 1'b1;
         r_digit_out  <= '0;
         r_dp_out     <= 1'b0;
         r_digit_sel  <= '0;
         r_blank      <= 1'b1;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_tc_early && w_last;

         if (w_take) begin
            r_shadow     <= bus.digits_in;
            r_shadow_dp  <= bus.dp_in;
            r_load_ready <= 1'b0;
         end
         if (w_swap) begin
            r_active     <= r_shadow;
            r_active_dp  <= r_shadow_dp;
            r_load_ready <= 1'b1;
         end

         case (r_state)
            BLANK: if (w_guard_end) begin
               r_state     <= SHOW;
               r_digit_sel <= w_suppress[r_idx] ? '0 : w_onehot;
               r_blank     <= w_suppress[r_idx];
            end
            SHOW: if (w_tc) begin
               r_state     <= BLANK;
               r_digit_sel <= '0;
               r_blank     <= 1'b1;
            end
         endcase

         if (w_tc) begin
            r_idx       <= w_idx_next;
            r_digit_out <= w_next_nib;
            r_dp_out    <= w_next_dp_bit;
         end
      end
   end

   assign bus.load_ready = r_load_ready;
   assign bus.digit_out  = r_digit_out;
   assign bus.dp_out     = r_dp_out;
   assign bus.digit_sel  = r_digit_sel;
   assign bus.blank      = r_blank;
   assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_display_scan_driver.sv
// Self-checking bench: per-cycle reference model of the scan plus directed scenarios.
// Expectations follow DISPLAY_LZB_EN when it is defined for the build.
module tb_display_scan_driver;
   localparam int NDIG = 4;
   localparam int TPD  = 8;
   localparam int BLK  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   display_scan_driver_if #(.NDIG(NDIG)) bus ();

   display_scan_driver #(.NDIG(NDIG), .TICKS_PER_DIGIT(TPD), .BLANK_TICKS(BLK)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: elapsed cycles since reset release, active/shadow values.
   int          m_t = 0;
   logic [15:0] m_act = '0, m_sh = '0;
   logic [3:0]  m_actdp = '0, m_shdp = '0;
   bit          m_full = 0;

   function automatic bit m_supp(input int s);
`ifdef DISPLAY_LZB_EN
      if (s == 0) return 1'b0;
      for (int i = s; i < NDIG; i++)
         if (m_act[i*4 +: 4] != 4'd0 || m_actdp[i]) return 1'b0;
      return 1'b1;
`else
      return (s < 0);
`endif
   endfunction

   always @(negedge clk) begin
      int  slot, ph;
      bit  on, fd;
      if (rst) begin
         m_t = 0; m_act = '0; m_actdp = '0; m_full = 0;
         check("rst_sel",   32'(bus.digit_sel),  32'd0);
         check("rst_blank", 32'(bus.blank),      32'd1);
         check("rst_fd",    32'(bus.frame_done), 32'd0);
         check("rst_ready", 32'(bus.load_ready), 32'd1);
         check("rst_out",   32'(bus.digit_out),  32'd0);
      end else begin
         slot = (m_t / TPD) % NDIG;
         ph   = m_t % TPD;
         on   = (ph >= BLK) && !m_supp(slot);
         fd   = (ph == TPD-1) && (slot == NDIG-1);
         check("m_sel",   32'(bus.digit_sel),  on ? 32'(1 << slot) : 32'd0);
         check("m_blank", 32'(bus.blank),      32'(!on));
         check("m_out",   32'(bus.digit_out),  32'(m_act[slot*4 +: 4]));
         check("m_dp",    32'(bus.dp_out),     32'(m_actdp[slot]));
         check("m_fd",    32'(bus.frame_done), 32'(fd));
         check("m_ready", 32'(bus.load_ready), 32'(!m_full));
         if (fd && m_full) begin
            m_act = m_sh; m_actdp = m_shdp; m_full = 0;
         end else if (bus.load && !m_full) begin
            m_sh = bus.digits_in; m_shdp = bus.dp_in; m_full = 1;
         end
         m_t++;
      end
   end

   task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
      @(posedge clk); #1;
      bus.load = 1'b1; bus.digits_in = d; bus.dp_in = dp;
      @(posedge clk); #1;
      bus.load = 1'b0;
   endtask

   task automatic wait_fd();
      int n;
      @(negedge clk);
      n = 1;
      while (!bus.frame_done && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("fd_timeout", 32'(bus.frame_done), 32'd1);
   endtask

   task automatic wait_sel(input logic [3:0] s);
      int n;
      n = 0;
      while (bus.digit_sel !== s && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("sel_timeout", 32'(bus.digit_sel), 32'(s));
   endtask

   task automatic sel_union(output logic [3:0] u);
      u = '0;
      for (int i = 0; i < NDIG*TPD; i++) begin
         @(negedge clk);
         u = u | bus.digit_sel;
      end
   endtask

   initial begin
      logic [3:0] exp_d [4];
      logic [3:0] u;
      int c1, n;
      exp_d = '{4'd4, 4'd3, 4'd2, 4'd1};
      bus.load = 1'b0; bus.digits_in = '0; bus.dp_in = '0;

      repeat (3) @(posedge clk);
      #1;
      check("lit_rst_sel",   32'(bus.digit_sel),  32'd0);
      check("lit_rst_ready", 32'(bus.load_ready), 32'd1);
      rst = 1'b0;

      // 1234 appears from the next frame, digit 0 first
      do_load(16'h1234, 4'b0000);
      wait_fd();
      for (int s = 0; s < NDIG; s++) begin
         for (int p = 0; p < TPD; p++) begin
            @(negedge clk);
            if (p == 0) check("lit_1234_blank", 32'(bus.blank), 32'd1);
            if (p == 3) begin
               check("lit_1234_out", 32'(bus.digit_out), 32'(exp_d[s]));
               check("lit_1234_sel", 32'(bus.digit_sel), 32'(4'b0001 << s));
            end
         end
      end

      // Second load while shadow full is held off until the boundary
      do_load(16'h1111, 4'b0000);
      bus.load = 1'b1; bus.digits_in = 16'h2222; bus.dp_in = '0;
      check("lit_busy_ready", 32'(bus.load_ready), 32'd0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.load_ready && n < 100);
      check("lit_ready_back", 32'(bus.load_ready), 32'd1);
      @(posedge clk); #1;
      bus.load = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("lit_show_1111", 32'(bus.digit_out), 32'd1);
      end
      wait_fd();
      @(negedge clk);
      check("lit_show_2222", 32'(bus.digit_out), 32'd2);

      // frame_done period
      wait_fd();
      c1 = cyc;
      wait_fd();
      check("lit_fd_period", 32'(cyc - c1), 32'd32);

      // Async reset in digit 2 SHOW with a value pending in the shadow
      wait_sel(4'b0010);
      do_load(16'h5555, 4'b0000);
      wait_sel(4'b0100);
      #2 rst = 1'b1;
      #1;
      check("lit_async_sel",   32'(bus.digit_sel),  32'd0);
      check("lit_async_blank", 32'(bus.blank),      32'd1);
      check("lit_async_ready", 32'(bus.load_ready), 32'd1);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("lit_restart_blank", 32'(bus.blank), 32'd1);
      @(negedge clk); @(negedge clk);
      check("lit_restart_sel", 32'(bus.digit_sel), 32'd1);
      wait_fd();
      @(negedge clk);
      check("lit_discard_out", 32'(bus.digit_out), 32'd0);

      // Leading-zero blanking
      do_load(16'h0045, 4'b0000);
      wait_fd(); wait_fd();
      sel_union(u);
`ifdef DISPLAY_LZB_EN
      check("lit_lzb_union", 32'(u), 32'b0011);
`else
      check("lit_lzb_union", 32'(u), 32'b1111);
`endif
      do_load(16'h0045, 4'b0100);
      wait_fd(); wait_fd();
      sel_union(u);
`ifdef DISPLAY_LZB_EN
      check("lit_lzb_dp_union", 32'(u), 32'b0111);
`else
      check("lit_lzb_dp_union", 32'(u), 32'b1111);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
